ppi_bus_initiator: RTL and testbench

Bus-initiator sequencer for the i8255 PPI's CPU-side register interface. It takes queued register read/write requests from an internal client (CPC gate-array glue, PSG/keyboard scan logic, loader FSM) and generates correctly timed `addr`/`cs`/`we`/`oe` cycles toward the `i8255` responder. It returns read data through a one-cycle response pulse. It sits between client logic and the `i8255` instance in the Aleste core, all on `clk_sys`.

---
 rtl/ppi_pkg.sv | 27 ++
 rtl/ppi_req_fifo.sv | 53 +++++
 rtl/ppi_bus_initiator.sv | 187 ++++++++++++++++++
 tb/tb_ppi_bus_initiator.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppi_pkg.sv
// ppi_pkg: shared types for the i8255 PPI bus initiator.
//   ppi_reg_e   : i8255 CPU-side register addresses (PA, PB, PC, CTRL)
//   ppi_op_t    : one queued register access {write, addr, wdata}
//   ppi_state_e : bus-cycle sequencer states
package ppi_pkg;

  typedef enum logic [1:0] {
    PPI_PA   = 2'd0,
    PPI_PB   = 2'd1,
    PPI_PC   = 2'd2,
    PPI_CTRL = 2'd3
  } ppi_reg_e;

  typedef struct packed {
    logic       write;
    logic [1:0] addr;
    logic [7:0] wdata;
  } ppi_op_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } ppi_state_e;

endpackage

// File: rtl/ppi_req_fifo.sv
// ppi_req_fifo: synchronous request queue of ppi_op_t entries.
// Ports:
//   clk_sys, reset_n : clock, asynchronous active-low reset (clears pointers)
//   push, din        : enqueue din on a rising edge when push is high
//   pop, dout        : dout shows the head entry; pop removes it
//   full, empty      : occupancy flags
//   count            : number of stored entries (0..DEPTH)
// DEPTH must be a power of two and at least 2.
module ppi_req_fifo
  import ppi_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic                     push,
  input  ppi_op_t                  din,
  input  logic                     pop,
  output ppi_op_t                  dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  ppi_op_t       mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count = wr_ptr - rd_ptr;
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ppi_bus_initiator.sv
// ppi_bus_initiator: sequences queued register reads/writes into timed
// addr/cs/we/oe cycles toward an i8255 responder.
// Ports:
//   clk_sys, reset_n      : system clock, asynchronous active-low reset
//   req_valid/req_ready   : request handshake (req_ready = queue not full)
//   req_write/addr/wdata  : request op (1 = write), register, write data
//   rsp_valid, rsp_rdata  : one-cycle completion pulse, read data (0 for writes)
//   busy                  : sequencer active or queue non-empty
//   addr, odata           : address and write data toward the i8255
//   idata                 : read data from the i8255
//   cs, we, oe            : active-high strobes
// Each op runs SETUP (SETUP_CYCLES) -> STROBE (STROBE_CYCLES) -> HOLD
// (HOLD_CYCLES) -> IDLE; IDLE pops the next queued op in the same cycle.
module ppi_bus_initiator
  import ppi_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [1:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic [1:0] addr,
  output logic [7:0] odata,
  input  logic [7:0] idata,
  output logic       cs,
  output logic       we,
  output logic       oe
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  // Phase counters load N-1 on entry and leave the phase at zero.
  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYCLES - 1);

  ppi_op_t          fifo_din;
  ppi_op_t          fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             push;
  logic             pop;

  ppi_state_e       state;
  ppi_state_e       state_nxt;
  logic [3:0]       cnt;
  logic [3:0]       cnt_nxt;
  logic             op_write;
  logic             write_nxt;
  logic             leave_strobe;
  logic             done;
  logic             rsp_pend;
  logic [7:0]       rd_cap;
  logic             cs_nxt;

  assign req_ready = !fifo_full;
  assign push      = req_valid && req_ready;
  assign fifo_din  = '{write: req_write, addr: req_addr, wdata: req_wdata};
  assign busy      = (state != ST_IDLE) || (fifo_count != '0);

  ppi_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .push    (push),
    .din     (fifo_din),
    .pop     (pop),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    pop          = 1'b0;
    write_nxt    = op_write;
    leave_strobe = 1'b0;
    done         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          write_nxt = fifo_dout.write;
          if (SETUP_CYCLES == 0) begin
            state_nxt = ST_STROBE;
            cnt_nxt   = STROBE_LD;
          end else begin
            state_nxt = ST_SETUP;
            cnt_nxt   = SETUP_LD;
          end
        end
      end
      ST_SETUP: begin
        if (cnt == 4'd0) begin
          state_nxt = ST_STROBE;
          cnt_nxt   = STROBE_LD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_STROBE: begin
        if (cnt == 4'd0) begin
          leave_strobe = 1'b1;
          if (HOLD_CYCLES == 0) begin
            state_nxt = ST_IDLE;
            done      = 1'b1;
          end else begin
            state_nxt = ST_HOLD;
            cnt_nxt   = HOLD_LD;
          end
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_HOLD: begin
        if (cnt == 4'd0) begin
          state_nxt = ST_IDLE;
          done      = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Strobes are registered from the next state so they never glitch, and
  // the write bit of the op being entered selects exactly one of we/oe.
  assign cs_nxt = (state_nxt == ST_STROBE);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      op_write  <= 1'b0;
      cs        <= 1'b0;
      we        <= 1'b0;
      oe        <= 1'b0;
      addr      <= '0;
      odata     <= '0;
      rsp_pend  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      op_write <= write_nxt;
      cs       <= cs_nxt;
      we       <= cs_nxt && write_nxt;
      oe       <= cs_nxt && !write_nxt;
      // addr/odata only change when a new op is popped; reads leave odata
      // at its last value so the responder bus stays quiet.
      if (pop) begin
        addr <= fifo_dout.addr;
        if (fifo_dout.write) odata <= fifo_dout.wdata;
      end
      // Completion is flagged on the edge entering IDLE and presented one
      // cycle later; rsp_rdata only changes together with rsp_valid.
      rsp_pend  <= done;
      rsp_valid <= rsp_pend;
      if (rsp_pend) rsp_rdata <= rd_cap;
    end
  end

  // Read capture on the edge leaving STROBE; consumed only after a
  // completed transaction, so it needs no reset.
  always_ff @(posedge clk_sys) begin
    if (leave_strobe) rd_cap <= op_write ? 8'h00 : idata;
  end

endmodule

// File: tb/tb_ppi_bus_initiator.sv
// tb_ppi_bus_initiator: directed bench for ppi_bus_initiator with a small
// registered i8255 register model. A second instance runs S=0, T=1, H=0.
module tb_ppi_bus_initiator;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // default-parameter instance
  logic       req_valid = 1'b0, req_write = 1'b0;
  logic [1:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       req_ready, rsp_valid, busy, cs, we, oe;
  logic [7:0] rsp_rdata, odata;
  logic [1:0] addr;
  logic [7:0] idata = '0;

  // fast instance
  logic       f_req_valid = 1'b0, f_req_write = 1'b0;
  logic [1:0] f_req_addr = '0;
  logic [7:0] f_req_wdata = '0;
  logic       f_req_ready, f_rsp_valid, f_busy, f_cs, f_we, f_oe;
  logic [7:0] f_rsp_rdata, f_odata;
  logic [1:0] f_addr;
  logic [7:0] f_idata = 8'hC3;

  ppi_bus_initiator dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .addr(addr), .odata(odata), .idata(idata),
    .cs(cs), .we(we), .oe(oe)
  );

  ppi_bus_initiator #(
    .FIFO_DEPTH(4), .SETUP_CYCLES(0), .STROBE_CYCLES(1), .HOLD_CYCLES(0)
  ) dut_fast (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .req_valid(f_req_valid), .req_ready(f_req_ready), .req_write(f_req_write),
    .req_addr(f_req_addr), .req_wdata(f_req_wdata),
    .rsp_valid(f_rsp_valid), .rsp_rdata(f_rsp_rdata), .busy(f_busy),
    .addr(f_addr), .odata(f_odata), .idata(f_idata),
    .cs(f_cs), .we(f_we), .oe(f_oe)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  a_excl: assert property (@(posedge clk_sys) disable iff (!reset_n) !(we && oe));
  a_cs:   assert property (@(posedge clk_sys) disable iff (!reset_n) (we || oe) |-> cs);

  // registered i8255 register model
  logic [7:0] regs [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] ipb = 8'h00;
  logic       we_d = 1'b0;
  logic [7:0] pa_log [$];

  always @(posedge clk_sys) begin
    we_d <= we;
    if (cs && we) regs[addr] <= odata;
    if (cs && we && !we_d && addr == 2'd0) pa_log.push_back(odata);
    idata <= (addr == 2'd1 && regs[3][1]) ? ipb : regs[addr];
  end

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // monitors (default instance)
  int cs_cnt, we_cnt, oe_cnt, rsp_cnt, rsp_cyc, viol = 0;
  int fall_cyc, gap_min, gap_max;
  logic [1:0] s_addr;
  logic [7:0] s_odata, rsp_last;
  logic cs_p = 1'b0, ready_low, scb_on = 1'b0;
  logic [7:0] exp_q [$];

  always @(negedge clk_sys) begin
    logic [7:0] e;
    if (cs) begin cs_cnt++; s_addr = addr; s_odata = odata; end
    if (we) we_cnt++;
    if (oe) oe_cnt++;
    if ((we && oe) || ((we || oe) && !cs)) viol++;
    if (!cs && cs_p) fall_cyc = cyc;
    if (cs && !cs_p && fall_cyc >= 0) begin
      if (cyc - fall_cyc < gap_min) gap_min = cyc - fall_cyc;
      if (cyc - fall_cyc > gap_max) gap_max = cyc - fall_cyc;
    end
    cs_p = cs;
    if (req_valid && !req_ready) ready_low = 1'b1;
    if (rsp_valid) begin
      rsp_cnt++; rsp_cyc = cyc; rsp_last = rsp_rdata;
      if (scb_on) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hEE;
        check_eq("scb_rdata", rsp_rdata, e);
      end
    end
  end

  // monitors (fast instance)
  int f_cs_cnt, f_rsp_cnt, f_rsp_cyc, f_fall, f_gmin, f_gmax;
  logic f_cs_p = 1'b0;
  logic [7:0] f_rsp_q [$];

  always @(negedge clk_sys) begin
    if (f_cs) f_cs_cnt++;
    if (!f_cs && f_cs_p) f_fall = cyc;
    if (f_cs && !f_cs_p && f_fall >= 0) begin
      if (cyc - f_fall < f_gmin) f_gmin = cyc - f_fall;
      if (cyc - f_fall > f_gmax) f_gmax = cyc - f_fall;
    end
    f_cs_p = f_cs;
    if (f_rsp_valid) begin f_rsp_cnt++; f_rsp_cyc = cyc; f_rsp_q.push_back(f_rsp_rdata); end
  end

  task automatic clear_mon();
    cs_cnt = 0; we_cnt = 0; oe_cnt = 0; rsp_cnt = 0; rsp_cyc = 0;
    fall_cyc = -1; gap_min = 999; gap_max = 0; ready_low = 1'b0;
    f_cs_cnt = 0; f_rsp_cnt = 0; f_rsp_cyc = 0; f_fall = -1; f_gmin = 999; f_gmax = 0;
    f_rsp_q.delete();
  endtask

  // Present a request and return after its accept edge (req_valid stays high).
  task automatic push_req(input logic w, input logic [1:0] a, input logic [7:0] d, output int acc);
    int n = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    while (!req_ready && n < 200) begin @(posedge clk_sys); #1; n++; end
    @(posedge clk_sys); #1;
    acc = cyc;
  endtask

  task automatic fpush(input logic w, input logic [1:0] a, input logic [7:0] d, output int acc);
    int n = 0;
    f_req_valid = 1'b1; f_req_write = w; f_req_addr = a; f_req_wdata = d;
    while (!f_req_ready && n < 200) begin @(posedge clk_sys); #1; n++; end
    @(posedge clk_sys); #1;
    acc = cyc;
  endtask

  task automatic wait_rsp(input string tag, input int n, input int budget);
    int k = 0;
    while (rsp_cnt < n && k < budget) begin @(posedge clk_sys); #1; k++; end
    check_eq(tag, rsp_cnt, n);
  endtask

  task automatic wait_frsp(input string tag, input int n, input int budget);
    int k = 0;
    while (f_rsp_cnt < n && k < budget) begin @(posedge clk_sys); #1; k++; end
    check_eq(tag, f_rsp_cnt, n);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int acc, snap, n;
    logic [7:0] shadow [3];
    logic w;
    logic [1:0] a;
    logic [7:0] d;

    clear_mon();
    repeat (3) @(posedge clk_sys);
    #1;
    // reset state
    check_eq("rst_ready", req_ready, 1);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_rdata", rsp_rdata, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_addr", addr, 0);
    check_eq("rst_odata", odata, 0);
    check_eq("rst_strobes", {cs, we, oe}, 0);
    check_eq("rst_f_ready", f_req_ready, 1);
    reset_n = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;

    // write 0x82 to CTRL
    clear_mon();
    push_req(1'b1, 2'd3, 8'h82, acc);
    req_valid = 1'b0;
    wait_rsp("t1_rsp", 1, 20);
    repeat (3) @(posedge clk_sys);
    #1;
    check_eq("t1_latency", rsp_cyc - acc, 6);
    check_eq("t1_cs_cycles", cs_cnt, 2);
    check_eq("t1_we_cycles", we_cnt, 2);
    check_eq("t1_oe_cycles", oe_cnt, 0);
    check_eq("t1_addr", s_addr, 3);
    check_eq("t1_odata", s_odata, 8'h82);
    check_eq("t1_rdata", rsp_last, 8'h00);
    check_eq("t1_one_rsp", rsp_cnt, 1);
    check_eq("t1_mode", regs[3], 8'h82);
    check_eq("t1_busy_after", busy, 0);

    // read PB with B configured as input
    ipb = 8'h5A;
    clear_mon();
    push_req(1'b0, 2'd1, 8'h00, acc);
    req_valid = 1'b0;
    wait_rsp("t2_rsp", 1, 20);
    repeat (3) @(posedge clk_sys);
    #1;
    check_eq("t2_latency", rsp_cyc - acc, 6);
    check_eq("t2_oe_cycles", oe_cnt, 2);
    check_eq("t2_we_cycles", we_cnt, 0);
    check_eq("t2_rdata", rsp_last, 8'h5A);
    check_eq("t2_rdata_held", rsp_rdata, 8'h5A);

    // PA output mode, then a held burst of 6 writes
    clear_mon();
    push_req(1'b1, 2'd3, 8'h80, acc);
    req_valid = 1'b0;
    wait_rsp("t3_mode_rsp", 1, 20);
    clear_mon();
    pa_log.delete();
    for (int i = 1; i <= 6; i++) push_req(1'b1, 2'd0, 8'(i), acc);
    req_valid = 1'b0;
    wait_rsp("t3_rsp", 6, 100);
    repeat (3) @(posedge clk_sys);
    #1;
    check_eq("t3_ready_dropped", ready_low, 1);
    check_eq("t3_pa_count", pa_log.size(), 6);
    for (int i = 0; i < 6; i++)
      check_eq($sformatf("t3_pa%0d", i), (pa_log.size() > i) ? pa_log[i] : 8'hEE, 8'(i + 1));
    check_eq("t3_gap_min", gap_min, 3);
    check_eq("t3_gap_max", gap_max, 3);
    check_eq("t3_rsp_count", rsp_cnt, 6);

    // reset during the second strobe cycle of a queued burst
    clear_mon();
    push_req(1'b1, 2'd2, 8'h11, acc);
    push_req(1'b1, 2'd2, 8'h22, acc);
    push_req(1'b1, 2'd2, 8'h33, acc);
    req_valid = 1'b0;
    n = 0;
    while (!cs && n < 50) begin @(posedge clk_sys); #1; n++; end
    check_eq("t4_cs_on", cs, 1);
    @(posedge clk_sys);
    #2;
    check_eq("t4_cs_before_rst", cs, 1);
    snap = rsp_cnt;
    reset_n = 1'b0;
    #1;
    check_eq("t4_cs_async", cs, 0);
    check_eq("t4_we_async", we, 0);
    check_eq("t4_oe_async", oe, 0);
    @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
    repeat (10) @(posedge clk_sys);
    #1;
    check_eq("t4_busy", busy, 0);
    check_eq("t4_ready", req_ready, 1);
    check_eq("t4_no_stale_rsp", rsp_cnt, snap);

    // fast timing instance: S=0, T=1, H=0
    clear_mon();
    fpush(1'b1, 2'd3, 8'h80, acc);
    f_req_valid = 1'b0;
    wait_frsp("t5_rsp", 1, 20);
    check_eq("t5_latency", f_rsp_cyc - acc, 3);
    repeat (2) @(posedge clk_sys);
    #1;
    clear_mon();
    fpush(1'b1, 2'd0, 8'hAA, acc);
    fpush(1'b1, 2'd1, 8'hBB, acc);
    fpush(1'b0, 2'd2, 8'h00, acc);
    fpush(1'b1, 2'd2, 8'hCC, acc);
    f_req_valid = 1'b0;
    wait_frsp("t5_b2b_rsp", 4, 40);
    check_eq("t5_cs_cycles", f_cs_cnt, 4);
    check_eq("t5_gap_min", f_gmin, 1);
    check_eq("t5_gap_max", f_gmax, 1);
    check_eq("t5_wr_rdata", (f_rsp_q.size() > 0) ? f_rsp_q[0] : 8'hEE, 8'h00);
    check_eq("t5_rd_rdata", (f_rsp_q.size() > 2) ? f_rsp_q[2] : 8'hEE, 8'hC3);

    // mixed reads/writes against a reference queue (ctrl = 0x80: all outputs)
    clear_mon();
    scb_on = 1'b1;
    shadow[0] = 8'h10; shadow[1] = 8'h20; shadow[2] = 8'h30;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'h00);
      push_req(1'b1, 2'(i), shadow[i], acc);
    end
    for (int i = 0; i < 24; i++) begin
      w = 1'($urandom_range(0, 1));
      a = 2'($urandom_range(0, 2));
      d = 8'($urandom_range(0, 255));
      if (w) begin shadow[a] = d; exp_q.push_back(8'h00); end
      else exp_q.push_back(shadow[a]);
      push_req(w, a, d, acc);
    end
    req_valid = 1'b0;
    wait_rsp("mix_rsp", 27, 400);
    check_eq("mix_queue_drained", exp_q.size(), 0);
    scb_on = 1'b0;
    check_eq("strobe_rules", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
